// File: rtl/register_file_2r1w_if.sv
// Port bundle for the 2-read/1-write register file: write port, two ALU read ports,
// debug observation port and the committed-write counter.
interface register_file_2r1w_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              regWrite;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readAddr1;
    logic [ADDR_W-1:0] readAddr2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [ADDR_W-1:0] debugAddr;
    logic [DATA_W-1:0] debugData;
    logic [15:0]       writeCount;

    modport master (
        output regWrite, writeAddr, writeData, readAddr1, readAddr2, debugAddr,
        input  readData1, readData2, debugData, writeCount
    );

    modport slave (
        input  regWrite, writeAddr, writeData, readAddr1, readAddr2, debugAddr,
        output readData1, readData2, debugData, writeCount
    );
endinterface

// File: rtl/register_file_2r1w.sv
// CPU register file, R0 hardwired to zero, combinational reads, synchronous active-high reset.
// Optional macro WRITE_BYPASS_EN forwards a same-cycle write onto matching read/debug ports.
module register_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input logic                  clock,
    input logic                  reset,
    register_file_2r1w_if.slave  bus
);

    // R0 has no storage; index range starts at 1.
    logic [DATA_W-1:0] regs [1:NREGS-1];
    logic [15:0]       writeCount;
    logic              commitWrite;

    assign commitWrite = bus.regWrite && (bus.writeAddr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            writeCount <= '0;
        end else if (commitWrite) begin
            regs[bus.writeAddr] <= bus.writeData;
            writeCount          <= writeCount + 16'd1;
        end
    end

`ifdef WRITE_BYPASS_EN
    // Forward only a write that will actually commit; reset suppresses the forward.
    function automatic logic bypassHit(
        input logic              rst,
        input logic              commit,
        input logic [ADDR_W-1:0] wAddr,
        input logic [ADDR_W-1:0] rAddr
    );
        return !rst && commit && (wAddr == rAddr);
    endfunction
`endif

    always_comb begin
        bus.readData1 = '0;
        if (bus.readAddr1 != '0) begin
            bus.readData1 = regs[bus.readAddr1];
        end
`ifdef WRITE_BYPASS_EN
        if (bypassHit(reset, commitWrite, bus.writeAddr, bus.readAddr1)) begin
            bus.readData1 = bus.writeData;
        end
`endif
    end

    always_comb begin
        bus.readData2 = '0;
        if (bus.readAddr2 != '0) begin
            bus.readData2 = regs[bus.readAddr2];
        end
`ifdef WRITE_BYPASS_EN
        if (bypassHit(reset, commitWrite, bus.writeAddr, bus.readAddr2)) begin
            bus.readData2 = bus.writeData;
        end
`endif
    end

    always_comb begin
        bus.debugData = '0;
        if (bus.debugAddr != '0) begin
            bus.debugData = regs[bus.debugAddr];
        end
`ifdef WRITE_BYPASS_EN
        if (bypassHit(reset, commitWrite, bus.writeAddr, bus.debugAddr)) begin
            bus.debugData = bus.writeData;
        end
`endif
    end

    assign bus.writeCount = writeCount;

endmodule
